// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector. Samples x once every DIV clocks
// and compares the most recent samples against a runtime-loadable pattern.
// Matches drive an active-low detect, a saturating counter and a 7-segment digit.
module seq_detector_param #(
    parameter int unsigned             PAT_W   = 8,
    parameter int unsigned             LEN_W   = 4,
    parameter int unsigned             DIV     = 20000000,
    parameter int unsigned             CNT_W   = 8,
    parameter logic [PAT_W-1:0]        DEF_PAT = 8'b00001010,
    parameter logic [LEN_W-1:0]        DEF_LEN = 4,
    parameter logic                    DEF_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             tick,
    output logic             y,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             g
);

    localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [LEN_W-1:0] PAT_MAX  = LEN_W'(PAT_W);

    logic [DIV_W-1:0] div_cnt;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic [6:0]       seg;

    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] new_fill;
    logic [PAT_W-1:0] new_hist;
    logic [PAT_W-1:0] mask;
    logic             sample;
    logic             hit;
    logic [3:0]       digit;
    logic [6:0]       seg_next;

    // Free-running divider; tick is registered so it is a clean one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == DIV_LAST);
        end
    end

    // Match evaluation on the post-shift history; a cfg_load on a tick suppresses the sample.
    always_comb begin
        sample   = tick & ~cfg_load;
        eff_len  = (len > PAT_MAX) ? PAT_MAX : len;
        new_hist = {hist[PAT_W-2:0], x};
        new_fill = (fill >= PAT_MAX) ? PAT_MAX : fill + 1'b1;
        mask     = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (LEN_W'(i) < eff_len);
        end
        hit = sample && (eff_len != '0) && (new_fill >= eff_len) &&
              ((new_hist & mask) == (pattern & mask));
    end

    // Config, history, detect output and saturating match counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= DEF_PAT;
            len         <= DEF_LEN;
            ovl         <= DEF_OVL;
            hist        <= '0;
            fill        <= '0;
            y           <= 1'b1;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
        end else if (cfg_load) begin
            pattern     <= cfg_pattern;
            len         <= cfg_len;
            ovl         <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            y           <= 1'b1;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            if (tick) begin
                hist <= new_hist;
                // Non-overlapping mode restarts the fill so the next match needs fresh samples.
                fill <= (hit && !ovl) ? '0 : new_fill;
                y    <= ~hit;
                if (hit) begin
                    match_pulse <= 1'b1;
                    if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end

    // Active-low segment pattern {a..g} for the decimal digit of the count.
    always_comb begin
        digit = 4'(match_cnt % 10);
        case (digit)
            4'd0:    seg_next = 7'b0000001;
            4'd1:    seg_next = 7'b1001111;
            4'd2:    seg_next = 7'b0010010;
            4'd3:    seg_next = 7'b0000110;
            4'd4:    seg_next = 7'b1001100;
            4'd5:    seg_next = 7'b0100100;
            4'd6:    seg_next = 7'b0100000;
            4'd7:    seg_next = 7'b0001111;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0000100;
            default: seg_next = 7'b1111111;
        endcase
    end

    // Segment register trails match_cnt by one cycle.
    always_ff @(posedge clk) begin
        if (rst) seg <= 7'b0000001;
        else     seg <= seg_next;
    end

    assign {a, b, c, d, e, f, g} = seg;

endmodule
